demod_chan_arb: RTL

// Shares the single demodulator datapath between NCH independent per-channel

---
 rtl/demod_chan_arb_if.sv | 25 ++
 rtl/demod_chan_arb.sv | 97 +++++++++
 2 files changed

// File: rtl/demod_chan_arb_if.sv
// Stream bundle between the per-channel sample sources and the demodulator input.
// The source side (master) drives the channel streams and the demodulator's ready.
interface demod_chan_arb_if #(
  parameter int NCH = 4,
  parameter int DW  = 24
);
  logic [NCH*DW-1:0] s_axis_tdata;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [1:0]        m_axis_tuser;
  logic              m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/demod_chan_arb.sv
// Round-robin arbiter sharing one demodulator between NCH sample streams;
// each forwarded sample is tagged with its channel index on tuser.
module demod_chan_arb #(
  parameter int NCH = 4,
  parameter int DW  = 24
) (
  input  logic            s_axis_aclk,
  input  logic            s_axis_aresetn,
  input  logic            en,
  input  logic            strict,
  demod_chan_arb_if.slave bus
);
  localparam logic [1:0] LAST = 2'(NCH - 1);
  localparam logic [2:0] NCH3 = 3'(NCH);

  logic [1:0]     ptr_reg;
  logic [DW-1:0]  tdata_reg;
  logic [1:0]     tuser_reg;
  logic           tlast_reg;
  logic           tvalid_reg;

  logic [DW-1:0]  ch_data [NCH];
  logic [NCH-1:0] grant;
  logic [NCH-1:0] tready;
  logic [1:0]     gidx;
  logic [1:0]     cand;
  logic [2:0]     sum3;
  logic           found;
  logic           ofree;
  logic           xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = bus.s_axis_tdata[gi*DW +: DW];
    end
  endgenerate

  assign ofree = ~tvalid_reg | bus.m_axis_tready;

  // Strict mode waits on ptr; otherwise search ptr, ptr+1, ... with wrap at NCH.
  always_comb begin
    grant = '0;
    gidx  = ptr_reg;
    found = 1'b0;
    cand  = ptr_reg;
    sum3  = '0;
    if (strict) begin
      if (bus.s_axis_tvalid[ptr_reg]) begin
        grant[ptr_reg] = 1'b1;
        found          = 1'b1;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        sum3 = {1'b0, ptr_reg} + 3'(k);
        if (sum3 >= NCH3) sum3 = sum3 - NCH3;
        cand = sum3[1:0];
        if (!found && bus.s_axis_tvalid[cand]) begin
          grant[cand] = 1'b1;
          gidx        = cand;
          found       = 1'b1;
        end
      end
    end
  end

  assign tready = grant & {NCH{s_axis_aresetn & en & ofree}};
  assign xfer   = found & s_axis_aresetn & en & ofree;

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      ptr_reg    <= '0;
      tdata_reg  <= '0;
      tuser_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
    end else begin
      if (xfer) begin
        tdata_reg  <= ch_data[gidx];
        tuser_reg  <= gidx;
        tlast_reg  <= (gidx == LAST);
        tvalid_reg <= 1'b1;
        ptr_reg    <= (gidx == LAST) ? 2'd0 : gidx + 2'd1;
      end else if (bus.m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
      // Disabling restarts the next round at channel 0.
      if (!en) ptr_reg <= '0;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.m_axis_tdata  = tdata_reg;
  assign bus.m_axis_tuser  = tuser_reg;
  assign bus.m_axis_tlast  = tlast_reg;
  assign bus.m_axis_tvalid = tvalid_reg;
endmodule
